inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
Circular FIFO between the instruction fetcher and the decoder. It buffers fetched instructions together with their PC and BTB prediction, and presents the head entry to the decoder. It pops an entry when the decoder reports a successful decode. It also paces the fetcher through a full signal and discards all contents when the ROB signals a pipeline clear (mispredict or exception).

Parameters:
IQ_SIZE_BITS, 4, log2 of entry count (DEPTH = 2**IQ_SIZE_BITS = 16).

Ports:
clk_in  input  1  system clock; all state updates on the rising edge.
rst_in  input  1  synchronous active-high reset.
rdy_in  input  1  global ready; when low, all state holds.
IF_flag  input  1  fetcher pushes one instruction this cycle.
IF_inst  input  32  fetched instruction word.
IF_PC  input  32  PC of the fetched instruction.
IF_BTB_PC  input  32  predicted next PC.
IF_BTB_predict  input  1  BTB predicted taken.
IQ_full  output  1  queue cannot accept a push this cycle.
IQ_flag  output  1  head entry valid and presented to the decoder.
IQ_inst  output  32  head instruction word.
IQ_PC  output  32  head PC.
IQ_BTB_PC  output  32  head predicted next PC.
IQ_BTB_predict  output  1  head prediction bit.
Dec_flag  input  1  decoder consumed the head this cycle (pop).
ROB_clear  input  1  flush the whole queue.

Behaviour:
- State:
  - head and tail pointers, IQ_SIZE_BITS wide, wrap modulo DEPTH.
  - count, IQ_SIZE_BITS+1 wide, range 0..DEPTH.
  - Per-entry storage: inst, PC, BTB_PC, BTB_predict.
- Reset (rst_in=1 at the edge): head=tail=count=0. This gives IQ_flag=0 and IQ_full=0; head data outputs read as 0. Reset overrides rdy_in and every other input. Reset mid-stream drops all entries.
- IQ_full = (count == DEPTH). It is combinational from registered state, with no lookahead.
- IQ_flag = (count != 0) && rdy_in && !ROB_clear. This is combinational.
- Head outputs:
  - Combinational reads of entry[head] when count != 0.
  - All forced to 0 when count == 0.
  - There is no bypass: a push becomes visible the cycle after it is written.
- Pop accepted = Dec_flag && IQ_flag. Dec_flag with IQ_flag=0 is ignored.
- Push accepted = IF_flag && (!IQ_full || pop accepted). Push while full and popping the same cycle is legal and keeps count at DEPTH.
- Push effect: write entry[tail]; tail = tail+1.
- Pop effect: head = head+1.
- count updates:
  - +1 for push only.
  - −1 for pop only.
  - Unchanged for both or neither.
- ROB_clear=1 (and rdy_in=1):
  - Next state is head=tail=count=0.
  - A push in the same cycle is dropped.
  - No pop is reported, because IQ_flag is forced low.
  - Priority order: rst_in > ROB_clear > push/pop.
- rdy_in=0: no pointer, count or storage change. IF_flag and Dec_flag are ignored. IQ_flag is low.
- Push on a full queue without a pop is a fetcher protocol violation. The queue drops the instruction and state is unchanged.
- Latency: an instruction pushed at edge N is presented with IQ_flag=1 during cycle N+1 at the earliest.
- Storage needs no reset; only pointers and count are reset.

Test Plan:
- Reset then idle: rst_in=1 for 2 cycles, then release → IQ_flag=0, IQ_full=0, IQ_inst=0 for at least 3 cycles.
- Single pass: push inst 0x00500093, PC 0x0, BTB_PC 0x4, predict 0; Dec_flag=1 → IQ_flag=1 exactly one cycle after the push with matching fields; then IQ_flag=0.
- Fill and wrap: push 16 entries (PC 0x0..0x3C) with Dec_flag=0 → IQ_full=1 and a 17th push is dropped. Then pop 4 and push 4 more (PC 0x40..0x4C) → pop order is PC 0x10..0x4C, tail wraps, count returns to 0.
- Full with simultaneous push+pop: with count=16, assert IF_flag and Dec_flag together → head advances, new entry stored, IQ_full stays 1, count stays 16.
- Flush: with 5 entries, assert ROB_clear with IF_flag=1 → next cycle IQ_flag=0 and count=0. The first new push after the flush appears as the head one cycle later.
- rdy_in low: with 3 entries, drop rdy_in for 4 cycles while toggling IF_flag and Dec_flag → IQ_flag=0 throughout. After rdy_in returns, the same 3 entries pop in their original order.

Source files
------------

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode. It is a circular buffer that holds the instruction, PC and BTB prediction.
// The head entry is presented combinationally. The queue is flushed by a ROB clear.
module inst_queue #(
    parameter int IQ_SIZE_BITS = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        IF_flag,
    input  logic [31:0] IF_inst,
    input  logic [31:0] IF_PC,
    input  logic [31:0] IF_BTB_PC,
    input  logic        IF_BTB_predict,
    output logic        IQ_full,
    output logic        IQ_flag,
    output logic [31:0] IQ_inst,
    output logic [31:0] IQ_PC,
    output logic [31:0] IQ_BTB_PC,
    output logic        IQ_BTB_predict,
    input  logic        Dec_flag,
    input  logic        ROB_clear
);
    localparam int DEPTH = 1 << IQ_SIZE_BITS;
    localparam logic [IQ_SIZE_BITS:0] DEPTH_CNT = (IQ_SIZE_BITS + 1)'(DEPTH);
    localparam logic [IQ_SIZE_BITS:0] CNT_ONE   = (IQ_SIZE_BITS + 1)'(1);
    localparam logic [IQ_SIZE_BITS-1:0] PTR_ONE = IQ_SIZE_BITS'(1);

    logic [31:0] inst_mem   [DEPTH];
    logic [31:0] pc_mem     [DEPTH];
    logic [31:0] btb_pc_mem [DEPTH];
    logic        predict_mem[DEPTH];

    logic [IQ_SIZE_BITS-1:0] head_reg, head_next;
    logic [IQ_SIZE_BITS-1:0] tail_reg, tail_next;
    logic [IQ_SIZE_BITS:0]   count_reg, count_next;

    logic not_empty;
    logic pop;
    logic push;

    assign not_empty = (count_reg != '0);
    assign IQ_full   = (count_reg == DEPTH_CNT);
    assign IQ_flag   = not_empty && rdy_in && !ROB_clear;

    // IQ_flag already carries rdy_in and !ROB_clear, so a pop is only seen when the queue is live.
    assign pop  = Dec_flag && IQ_flag;
    assign push = IF_flag && rdy_in && !ROB_clear && (!IQ_full || pop);

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (ROB_clear) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (pop)
                head_next = head_reg + PTR_ONE;
            if (push)
                tail_next = tail_reg + PTR_ONE;
            if (push && !pop)
                count_next = count_reg + CNT_ONE;
            else if (pop && !push)
                count_next = count_reg - CNT_ONE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (rdy_in) begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Storage has no reset. A stale slot is never visible because count gates the head outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_in && push) begin
            inst_mem[tail_reg]    <= IF_inst;
            pc_mem[tail_reg]      <= IF_PC;
            btb_pc_mem[tail_reg]  <= IF_BTB_PC;
            predict_mem[tail_reg] <= IF_BTB_predict;
        end
    end

    always_comb begin
        IQ_inst        = '0;
        IQ_PC          = '0;
        IQ_BTB_PC      = '0;
        IQ_BTB_predict = 1'b0;
        if (not_empty) begin
            IQ_inst        = inst_mem[head_reg];
            IQ_PC          = pc_mem[head_reg];
            IQ_BTB_PC      = btb_pc_mem[head_reg];
            IQ_BTB_predict = predict_mem[head_reg];
        end
    end
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue. It covers reset, single pass, fill/wrap, full push+pop, flush, rdy stall and mid-stream reset.
module tb_inst_queue;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        IF_flag, IF_BTB_predict, Dec_flag, ROB_clear;
    logic [31:0] IF_inst, IF_PC, IF_BTB_PC;
    logic        IQ_full, IQ_flag, IQ_BTB_predict;
    logic [31:0] IQ_inst, IQ_PC, IQ_BTB_PC;

    integer checks = 0;
    integer errors = 0;

    inst_queue #(.IQ_SIZE_BITS(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .IF_flag(IF_flag), .IF_inst(IF_inst), .IF_PC(IF_PC),
        .IF_BTB_PC(IF_BTB_PC), .IF_BTB_predict(IF_BTB_predict),
        .IQ_full(IQ_full), .IQ_flag(IQ_flag), .IQ_inst(IQ_inst),
        .IQ_PC(IQ_PC), .IQ_BTB_PC(IQ_BTB_PC), .IQ_BTB_predict(IQ_BTB_predict),
        .Dec_flag(Dec_flag), .ROB_clear(ROB_clear)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entries generated by the bench carry fields that follow from their PC.
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'h1000_0000 + (pc >> 2);
    endfunction

    function automatic logic pred_of(input logic [31:0] pc);
        logic [31:0] w;
        w = pc >> 2;
        return w[0];
    endfunction

    task automatic drive_entry(input logic [31:0] pc);
        IF_PC          = pc;
        IF_inst        = inst_of(pc);
        IF_BTB_PC      = pc + 32'd4;
        IF_BTB_predict = pred_of(pc);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_flag"}, {31'd0, IQ_flag}, 32'd1);
        chk({tag, "_pc"}, IQ_PC, pc);
        chk({tag, "_inst"}, IQ_inst, inst_of(pc));
        chk({tag, "_btb"}, IQ_BTB_PC, pc + 32'd4);
        chk({tag, "_pred"}, {31'd0, IQ_BTB_predict}, {31'd0, pred_of(pc)});
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; IF_flag = 1'b0; Dec_flag = 1'b0; ROB_clear = 1'b0;
        IF_inst = '0; IF_PC = '0; IF_BTB_PC = '0; IF_BTB_predict = 1'b0;
        tick(); tick();
        rst_in = 1'b0;

        // Reset then idle
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("idle_flag", {31'd0, IQ_flag}, 32'd0);
            chk("idle_full", {31'd0, IQ_full}, 32'd0);
            chk("idle_inst", IQ_inst, 32'd0);
            tick();
        end

        // Single pass: Dec_flag on an empty queue is ignored
        IF_flag = 1'b1; IF_inst = 32'h0050_0093; IF_PC = 32'h0; IF_BTB_PC = 32'h4;
        IF_BTB_predict = 1'b0; Dec_flag = 1'b1;
        #1 chk("sp_pre_flag", {31'd0, IQ_flag}, 32'd0);
        tick();
        IF_flag = 1'b0;
        #1;
        chk("sp_flag", {31'd0, IQ_flag}, 32'd1);
        chk("sp_inst", IQ_inst, 32'h0050_0093);
        chk("sp_pc", IQ_PC, 32'h0);
        chk("sp_btb", IQ_BTB_PC, 32'h4);
        chk("sp_pred", {31'd0, IQ_BTB_predict}, 32'd0);
        tick();
        Dec_flag = 1'b0;
        #1 chk("sp_post_flag", {31'd0, IQ_flag}, 32'd0);

        // Fill 16 entries
        IF_flag = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive_entry(32'(i * 4));
            #1 chk("fill_notfull", {31'd0, IQ_full}, 32'd0);
            tick();
        end
        drive_entry(32'h999);
        #1;
        chk("fill_full", {31'd0, IQ_full}, 32'd1);
        chk_head("fill_head", 32'h0);
        tick();
        IF_flag = 1'b0;
        #1;
        chk("drop_full", {31'd0, IQ_full}, 32'd1);
        chk_head("drop_head", 32'h0);

        // Pop four entries
        Dec_flag = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk_head("pop4", 32'(k * 4));
            tick();
        end
        Dec_flag = 1'b0;
        #1 chk("pop4_notfull", {31'd0, IQ_full}, 32'd0);

        // Push four more; the tail wraps around
        IF_flag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_entry(32'h40 + 32'(i * 4));
            tick();
        end
        IF_flag = 1'b0;
        #1;
        chk("refill_full", {31'd0, IQ_full}, 32'd1);
        chk_head("refill_head", 32'h10);

        // Push and pop together while full
        IF_flag = 1'b1; Dec_flag = 1'b1;
        drive_entry(32'h50);
        tick();
        IF_flag = 1'b0;
        #1;
        chk("pp_full", {31'd0, IQ_full}, 32'd1);
        chk_head("pp_head", 32'h14);

        // Drain all 16 entries in order
        for (int k = 0; k < 16; k++) begin
            #1 chk_head("drain", 32'h14 + 32'(k * 4));
            tick();
        end
        Dec_flag = 1'b0;
        #1;
        chk("drain_empty", {31'd0, IQ_flag}, 32'd0);
        chk("drain_notfull", {31'd0, IQ_full}, 32'd0);
        chk("drain_inst0", IQ_inst, 32'd0);

        // Flush with five entries and a push in the same cycle
        IF_flag = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_entry(32'h100 + 32'(i * 4));
            tick();
        end
        ROB_clear = 1'b1;
        drive_entry(32'h200);
        #1 chk("clr_flag_low", {31'd0, IQ_flag}, 32'd0);
        tick();
        ROB_clear = 1'b0; IF_flag = 1'b0;
        #1;
        chk("clr_empty", {31'd0, IQ_flag}, 32'd0);
        chk("clr_inst0", IQ_inst, 32'd0);
        IF_flag = 1'b1;
        drive_entry(32'h300);
        tick();
        IF_flag = 1'b0;
        #1 chk_head("clr_new", 32'h300);
        Dec_flag = 1'b1;
        tick();
        Dec_flag = 1'b0;
        #1 chk("clr_drained", {31'd0, IQ_flag}, 32'd0);

        // Stall with three entries: rdy low blocks both push and pop
        IF_flag = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_entry(32'h400 + 32'(i * 4));
            tick();
        end
        rdy_in = 1'b0;
        drive_entry(32'h500);
        for (int i = 0; i < 4; i++) begin
            IF_flag = (i % 2 == 0); Dec_flag = (i % 2 == 1) || (i == 2);
            #1 chk("stall_flag", {31'd0, IQ_flag}, 32'd0);
            tick();
        end
        rdy_in = 1'b1; IF_flag = 1'b0; Dec_flag = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk_head("stall_pop", 32'h400 + 32'(k * 4));
            tick();
        end
        Dec_flag = 1'b0;
        #1 chk("stall_empty", {31'd0, IQ_flag}, 32'd0);

        // Reset mid-stream drops all entries
        IF_flag = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_entry(32'h600 + 32'(i * 4));
            tick();
        end
        IF_flag = 1'b0; rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        #1;
        chk("rst_mid_flag", {31'd0, IQ_flag}, 32'd0);
        chk("rst_mid_inst", IQ_inst, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
